// File: rtl/rtr_la_route_calc.sv
// Lookahead route calculation for phased DOR: next-hop router address + destination info -> {port, class}.
// Optional sticky address range error output enabled by defining RTR_LA_ROUTE_ERR_CHECK_EN.
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif
`ifndef CONNECTIVITY_FULL
`define CONNECTIVITY_FULL 2
`endif
`ifndef ROUTING_TYPE_PHASED_DOR
`define ROUTING_TYPE_PHASED_DOR 0
`endif

module rtr_la_route_calc #(
    parameter int unsigned num_resource_classes = 2,
    parameter int unsigned num_routers_per_dim  = 4,
    parameter int unsigned num_dimensions       = 2,
    parameter int unsigned num_nodes_per_router = 1,
    parameter int unsigned connectivity         = `CONNECTIVITY_LINE,
    parameter int unsigned routing_type         = `ROUTING_TYPE_PHASED_DOR,
    localparam int unsigned dim_addr_width      = $clog2(num_routers_per_dim),
    localparam int unsigned router_addr_width   = num_dimensions * dim_addr_width,
    localparam int unsigned node_addr_width     = $clog2(num_nodes_per_router),
    localparam int unsigned num_neighbors_per_dim =
        (connectivity == `CONNECTIVITY_FULL) ? num_routers_per_dim - 1 : 2,
    localparam int unsigned num_ports =
        num_dimensions * num_neighbors_per_dim + num_nodes_per_router,
    localparam int unsigned port_idx_width           = $clog2(num_ports),
    localparam int unsigned resource_class_idx_width = $clog2(num_resource_classes),
    localparam int unsigned dest_info_width =
        num_resource_classes * router_addr_width + node_addr_width,
    localparam int unsigned lar_info_width = port_idx_width + resource_class_idx_width
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [router_addr_width-1:0]        in_router_address,
    input  logic [dest_info_width-1:0]          in_dest_info,
    input  logic [resource_class_idx_width-1:0] in_resource_class,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [lar_info_width-1:0]           out_lar_info,
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
    output logic                                err_addr_range,
`endif
    output logic [dest_info_width-1:0]          out_dest_info
);
    localparam int unsigned DW  = dim_addr_width;
    localparam int unsigned RAW = router_addr_width;
    localparam int unsigned PW  = port_idx_width;
    localparam int unsigned RCW = resource_class_idx_width;
    localparam int unsigned PLW = lar_info_width + dest_info_width;

    if (routing_type != `ROUTING_TYPE_PHASED_DOR) begin : g_bad_routing_type
        $error("rtr_la_route_calc: only phased DOR routing is supported");
    end

    logic [RCW-1:0] rc;
    logic [RAW-1:0] dest_cur;
    logic [DW-1:0]  cur, dst;
    logic [DW:0]    diff, up;
    logic [PW-1:0]  port, node_port;

    if (node_addr_width > 0) begin : g_node
        assign node_port = PW'(in_dest_info[num_resource_classes*RAW +: node_addr_width]);
    end else begin : g_no_node
        assign node_port = '0;
    end

    // Class advance, destination select and port select; dim 0 occupies the address MSBs
    always_comb begin
        rc = in_resource_class;
        for (int k = 0; k < int'(num_resource_classes) - 1; k++) begin
            if (rc == RCW'(k) && in_router_address == in_dest_info[k*RAW +: RAW])
                rc = RCW'(k + 1);
        end
        dest_cur = in_dest_info[0 +: RAW];
        for (int k = 1; k < int'(num_resource_classes); k++) begin
            if (rc == RCW'(k))
                dest_cur = in_dest_info[k*RAW +: RAW];
        end
        cur  = '0;
        dst  = '0;
        diff = '0;
        up   = '0;
        port = '0;
        // Descending scan so the lowest differing dimension wins
        for (int d = int'(num_dimensions) - 1; d >= 0; d--) begin
            cur  = in_router_address[(int'(num_dimensions) - 1 - d)*DW +: DW];
            dst  = dest_cur[(int'(num_dimensions) - 1 - d)*DW +: DW];
            diff = (DW+1)'(dst) - (DW+1)'(cur);
            up   = diff[DW] ? diff + (DW+1)'(num_routers_per_dim) : diff;
            if (cur != dst) begin
                case (connectivity)
                    `CONNECTIVITY_RING:
                        port = (up <= (DW+1)'(num_routers_per_dim / 2)) ? PW'(2*d + 1) : PW'(2*d);
                    `CONNECTIVITY_FULL:
                        port = PW'(d * (int'(num_routers_per_dim) - 1)) + PW'(up) - PW'(1);
                    default:
                        port = diff[DW] ? PW'(2*d) : PW'(2*d + 1);
                endcase
            end
        end
        if (in_router_address == dest_cur)
            port = PW'(num_dimensions * num_neighbors_per_dim) + node_port;
    end

    // Two-entry elastic buffer: main register drives the output, skid absorbs one stall
    logic           main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic [PLW-1:0] main_q, main_d, skid_q, skid_d, entry;
    logic           push, pop;

    assign in_ready = ~skid_vld_q;
    assign push     = in_valid & ~skid_vld_q;
    assign pop      = main_vld_q & out_ready;
    assign entry    = {port, rc, in_dest_info};

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_d     = main_q;
        skid_d     = skid_q;
        if (pop) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = push;
                if (push)
                    main_d = entry;
            end
        end else if (push) begin
            if (main_vld_q) begin
                skid_d     = entry;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = entry;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign out_valid     = main_vld_q;
    assign out_lar_info  = main_q[PLW-1 -: lar_info_width];
    assign out_dest_info = main_q[dest_info_width-1:0];

`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
    logic err_q, err_d, bad;

    // Flag any out-of-range dimension field or class on an accepted flit; sticky until reset
    always_comb begin
        bad = 32'(in_resource_class) >= num_resource_classes;
        for (int d = 0; d < int'(num_dimensions); d++) begin
            if (32'(in_router_address[d*DW +: DW]) >= num_routers_per_dim ||
                32'(dest_cur[d*DW +: DW]) >= num_routers_per_dim)
                bad = 1'b1;
        end
        err_d = err_q | (push & bad);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err_addr_range = err_q;
`endif

endmodule

// File: tb/tb_rtr_la_route_calc.sv
// Directed bench for rtr_la_route_calc: LINE 4x4 main instance, RING 4x4 instance,
// and a RING 3x3 error-check instance when RTR_LA_ROUTE_ERR_CHECK_EN is defined.
`ifndef CONNECTIVITY_LINE
`define CONNECTIVITY_LINE 0
`endif
`ifndef CONNECTIVITY_RING
`define CONNECTIVITY_RING 1
`endif

module tb_rtr_la_route_calc;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    // LINE 4x4 instance
    logic       in_valid, in_ready, out_valid, out_ready, in_rc;
    logic [3:0] in_router, out_lar;
    logic [7:0] in_dest, out_dest;
    // RING 4x4 instance
    logic       r_valid, r_ready, r_out_valid;
    logic [3:0] r_router, r_lar;
    logic [7:0] r_dest, r_out_dest;
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
    logic       l_err, r_err, e_err, e_valid, e_ready, e_out_valid;
    logic [3:0] e_router, e_lar;
    logic [7:0] e_dest, e_out_dest;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rtr_la_route_calc #(.connectivity(`CONNECTIVITY_LINE)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_router_address(in_router), .in_dest_info(in_dest), .in_resource_class(in_rc),
        .out_valid(out_valid), .out_ready(out_ready), .out_lar_info(out_lar),
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
        .err_addr_range(l_err),
`endif
        .out_dest_info(out_dest)
    );

    rtr_la_route_calc #(.connectivity(`CONNECTIVITY_RING)) dut_ring (
        .clk(clk), .reset(rst),
        .in_valid(r_valid), .in_ready(r_ready),
        .in_router_address(r_router), .in_dest_info(r_dest), .in_resource_class(1'b0),
        .out_valid(r_out_valid), .out_ready(1'b1), .out_lar_info(r_lar),
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
        .err_addr_range(r_err),
`endif
        .out_dest_info(r_out_dest)
    );

`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
    rtr_la_route_calc #(.connectivity(`CONNECTIVITY_RING), .num_routers_per_dim(3)) dut_err (
        .clk(clk), .reset(rst),
        .in_valid(e_valid), .in_ready(e_ready),
        .in_router_address(e_router), .in_dest_info(e_dest), .in_resource_class(1'b0),
        .out_valid(e_out_valid), .out_ready(1'b1), .out_lar_info(e_lar),
        .err_addr_range(e_err),
        .out_dest_info(e_out_dest)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one flit to the LINE instance for one clock edge
    task automatic send(input logic [3:0] r, input logic [7:0] d, input logic rc);
        in_router = r;
        in_dest   = d;
        in_rc     = rc;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic rsend(input logic [3:0] r, input logic [7:0] d);
        r_router = r;
        r_dest   = d;
        r_valid  = 1'b1;
        @(negedge clk);
        r_valid  = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; in_router = '0; in_dest = '0; in_rc = 1'b0;
        r_valid = 1'b0; r_router = '0; r_dest = '0;
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
        e_valid = 1'b0; e_router = '0; e_dest = '0;
`endif
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_lar", 32'(out_lar), 32'd0);
        chk("rst_dest", 32'(out_dest), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
        chk("err_after_rst", 32'(e_err), 32'd0);
`endif

        // Plain routing, back-to-back with out_ready held high
        send(4'b0110, 8'h0E, 1'b0);
        chk("adv_valid", 32'(out_valid), 32'd1);
        chk("adv_lar", 32'(out_lar), 32'b0010);
        chk("adv_dest", 32'(out_dest), 32'h0E);
        send(4'b1110, 8'h0E, 1'b0);
        chk("class_adv_lar", 32'(out_lar), 32'b0001);
        send(4'b0000, 8'h09, 1'b1);
        chk("eject_lar", 32'(out_lar), 32'b1001);
        chk("eject_dest", 32'(out_dest), 32'h09);
        send(4'b1001, 8'h0B, 1'b0);
        chk("y_plus_lar", 32'(out_lar), 32'b0110);
        send(4'b0101, 8'h40, 1'b1);
        chk("y_minus_rc1_lar", 32'(out_lar), 32'b0101);
        @(negedge clk);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Backpressure: A, B fill the buffer, C is held
        out_ready = 1'b0;
        in_router = 4'b0000; in_dest = 8'h04; in_rc = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_a_ready", 32'(in_ready), 32'd1);
        chk("bp_a_lar", 32'(out_lar), 32'b0010);
        in_dest = 8'h01;
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        in_router = 4'b1000; in_dest = 8'hF0;
        @(negedge clk);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_lar", 32'(out_lar), 32'b0010);
        chk("bp_hold_dest", 32'(out_dest), 32'h04);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_lar", 32'(out_lar), 32'b0110);
        chk("bp_b_dest", 32'(out_dest), 32'h01);
        chk("bp_b_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        chk("bp_c_lar", 32'(out_lar), 32'b0000);
        chk("bp_c_dest", 32'(out_dest), 32'hF0);
        @(negedge clk);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);

        // Reset with both entries held
        out_ready = 1'b0;
        in_router = 4'b0000; in_dest = 8'h04; in_valid = 1'b1;
        @(negedge clk);
        in_dest = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        // RING 4x4 direction choice
        rsend(4'b0000, 8'h08);
        chk("ring_valid", 32'(r_out_valid), 32'd1);
        chk("ring_tie_up", 32'(r_lar), 32'b0010);
        rsend(4'b0000, 8'h0C);
        chk("ring_down", 32'(r_lar), 32'b0000);
        rsend(4'b0000, 8'h04);
        chk("ring_up1", 32'(r_lar), 32'b0010);
        rsend(4'b0011, 8'h00);
        chk("ring_wrap_y", 32'(r_lar), 32'b0110);

`ifdef RTR_LA_ROUTE_ERR_CHECK_EN
        e_router = 4'b0000; e_dest = 8'h0C; e_valid = 1'b1;
        @(negedge clk);
        e_router = 4'b0000; e_dest = 8'h04;
        chk("err_set", 32'(e_err), 32'd1);
        @(negedge clk);
        e_valid = 1'b0;
        @(negedge clk);
        chk("err_sticky", 32'(e_err), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
